// File: rtl/tcdm_varlat_pkg.sv
// Shared sizing helpers for the variable-latency TCDM master-side logic.
package tcdm_varlat_pkg;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

    // Bank-index width; never collapses to zero bits for a single bank.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr_dec_resp_mux_varlat_mo.sv
// Per-master address decoder / response mux with multiple outstanding
// transactions, all restricted to a single bank so responses stay in order.
module addr_dec_resp_mux_varlat_mo
    import tcdm_varlat_pkg::*;
#(
    parameter int          NumOut         = 32,
    parameter int          ReqDataWidth   = 32,
    parameter int          RespDataWidth  = 32,
    parameter int          MaxOutstanding = 4,
    parameter logic        WriteRespOn    = 1'b1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     req_i,
    input  logic [idx_w(NumOut)-1:0]                 add_i,
    input  logic                                     wen_i,
    input  logic [ReqDataWidth-1:0]                  data_i,
    output logic                                     gnt_o,
    output logic                                     vld_o,
    output logic [RespDataWidth-1:0]                 rdata_o,
    output logic                                     err_o,
    output logic [NumOut-1:0]                        req_o,
    input  logic [NumOut-1:0]                        gnt_i,
    input  logic [NumOut-1:0]                        vld_i,
    output logic [NumOut-1:0][ReqDataWidth-1:0]      data_o,
    input  logic [NumOut-1:0][RespDataWidth-1:0]     rdata_i
);

    localparam int AddrW = idx_w(NumOut);
    localparam int CntW  = clog2p1(MaxOutstanding);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    if (NumOut < 1) begin : g_bad_numout
        $fatal(1, "addr_dec_resp_mux_varlat_mo: NumOut must be >= 1");
    end
    if (MaxOutstanding < 1) begin : g_bad_maxout
        $fatal(1, "addr_dec_resp_mux_varlat_mo: MaxOutstanding must be >= 1");
    end

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AddrW-1:0]  bank_q, add_eff;
    logic              err_q;
    logic              tracked, pop, push, drained, accept_ok;
    logic              gnt_sel, vld_head;
    logic [NumOut-1:0] pop_mask;

    // With a single bank the index is meaningless, so pin it to zero.
    assign add_eff = (NumOut == 1) ? '0 : add_i;
    assign tracked = ~wen_i | WriteRespOn;

    always_comb begin
        gnt_sel  = 1'b0;
        vld_head = 1'b0;
        rdata_o  = '0;
        for (int i = 0; i < NumOut; i++) begin
            if (AddrW'(i) == add_eff) gnt_sel = gnt_i[i];
            if (AddrW'(i) == bank_q) begin
                vld_head = vld_i[i];
                rdata_o  = rdata_i[i];
            end
        end
    end

    assign pop     = (cnt_q != '0) & vld_head;
    assign drained = (cnt_q == '0) | ((cnt_q == CntW'(1)) & pop);
    // Same-bank issue is allowed while there is room, or at full when a slot frees this cycle.
    assign accept_ok = ~tracked | drained
                     | ((add_eff == bank_q) & ((cnt_q < MaxCnt) | pop));

    assign gnt_o = req_i & accept_ok & gnt_sel;
    assign push  = gnt_o & tracked;
    assign vld_o = pop;
    assign err_o = err_q;

    always_comb begin
        for (int i = 0; i < NumOut; i++) begin
            req_o[i]    = req_i & accept_ok & (AddrW'(i) == add_eff);
            pop_mask[i] = (cnt_q != '0) & (AddrW'(i) == bank_q);
            data_o[i]   = data_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            bank_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (push) bank_q <= add_eff;
            err_q <= err_q | (|(vld_i & ~pop_mask));
        end
    end

endmodule

// File: tb/tb_addr_dec_resp_mux_varlat_mo.sv
// Bench for addr_dec_resp_mux_varlat_mo: vector table plus hand sequences,
// responses checked against a scoreboard of expected banks.
module tb_addr_dec_resp_mux_varlat_mo;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            req_i, wen_i;
    logic [1:0]      add_i;
    logic [DW-1:0]   data_i;
    logic [N-1:0]    gnt_i, vld_i;
    logic [N-1:0][DW-1:0] rdata_i;

    logic            gnt_o, vld_o, err_o;
    logic [DW-1:0]   rdata_o;
    logic [N-1:0]    req_o;
    logic [N-1:0][DW-1:0] data_o;

    logic            nw_gnt_o, nw_vld_o, nw_err_o;
    logic [DW-1:0]   nw_rdata_o;
    logic [N-1:0]    nw_req_o;
    logic [N-1:0][DW-1:0] nw_data_o;

    int checks = 0;
    int failures = 0;
    logic [1:0] sb[$];

    always #5 clk = ~clk;

    addr_dec_resp_mux_varlat_mo #(
        .NumOut(N), .ReqDataWidth(DW), .RespDataWidth(DW),
        .MaxOutstanding(4), .WriteRespOn(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .data_i(data_i), .gnt_o(gnt_o), .vld_o(vld_o), .rdata_o(rdata_o),
        .err_o(err_o), .req_o(req_o), .gnt_i(gnt_i), .vld_i(vld_i),
        .data_o(data_o), .rdata_i(rdata_i)
    );

    addr_dec_resp_mux_varlat_mo #(
        .NumOut(N), .ReqDataWidth(DW), .RespDataWidth(DW),
        .MaxOutstanding(4), .WriteRespOn(1'b0)
    ) dut_nw (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .data_i(data_i), .gnt_o(nw_gnt_o), .vld_o(nw_vld_o), .rdata_o(nw_rdata_o),
        .err_o(nw_err_o), .req_o(nw_req_o), .gnt_i(gnt_i), .vld_i(vld_i),
        .data_o(nw_data_o), .rdata_i(rdata_i)
    );

    typedef struct {
        logic       r;
        logic [1:0] a;
        logic       w;
        logic [3:0] g;
        logic [3:0] v;
        logic [3:0] ereq;
        logic       egnt;
        logic       evld;
        logic       eerr;
    } vec_t;

    function automatic logic [DW-1:0] rd_val(input logic [1:0] b);
        return 32'hA5A0_0000 | {30'd0, b} | ({30'd0, b} << 8);
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1; req_i = 1'b0; wen_i = 1'b0; add_i = '0;
        gnt_i = '0; vld_i = '0;
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, track scoreboard.
    task automatic cyc(input logic r, input logic [1:0] a, input logic w,
                       input logic [3:0] g, input logic [3:0] v,
                       input logic [3:0] ereq, input logic egnt, input logic evld,
                       input logic eerr, input string nm);
        logic [DW-1:0] d;
        logic [1:0]    hb;
        @(negedge clk);
        d = $urandom;
        req_i = r; add_i = a; wen_i = w; gnt_i = g; vld_i = v; data_i = d;
        #1;
        chk({nm, " req_o"}, {28'd0, req_o}, {28'd0, ereq});
        chk({nm, " gnt_o"}, {31'd0, gnt_o}, {31'd0, egnt});
        chk({nm, " vld_o"}, {31'd0, vld_o}, {31'd0, evld});
        chk({nm, " err_o"}, {31'd0, err_o}, {31'd0, eerr});
        for (int i = 0; i < N; i++) chk({nm, " data_o"}, data_o[i], d);
        if (vld_o) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL %s sb: response with no outstanding entry", nm);
            end else begin
                hb = sb.pop_front();
                chk({nm, " rdata_o"}, rdata_o, rd_val(hb));
            end
        end
        if (egnt) sb.push_back(a);
    endtask

    task automatic after_edge_cnt(input string nm, input logic [2:0] ecnt);
        @(posedge clk); #1;
        chk({nm, " cnt"}, {29'd0, dut.cnt_q}, {29'd0, ecnt});
    endtask

    vec_t tbl[22];

    initial begin
        rst_i = 1'b0; req_i = 1'b0; wen_i = 1'b0; add_i = '0; data_i = '0;
        gnt_i = '0; vld_i = '0;
        for (int b = 0; b < N; b++) rdata_i[b] = rd_val(2'(b));

        //            r     a      w     g      v        ereq     gnt   vld   err
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 4'hF, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'd2, 1'b0, 4'hF, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 4'hF, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'd2, 1'b0, 4'hF, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 2'd2, 1'b0, 4'hF, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2'd2, 1'b0, 4'hF, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 4'hF, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 4'hF, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 4'hF, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 4'hF, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 4'hF, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 4'hF, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 2'd3, 1'b0, 4'hF, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 2'd3, 1'b0, 4'hF, 4'b0010, 4'b1000, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 2'd0, 1'b0, 4'hF, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 4'hF, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 2'd0, 1'b0, 4'h0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 2'd0, 1'b0, 4'h0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 2'd2, 1'b1, 4'hF, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 2'd1, 1'b0, 4'hF, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 2'd0, 1'b0, 4'hF, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0};

        do_reset();
        chk("reset cnt", {29'd0, dut.cnt_q}, 32'd0);
        chk("reset err", {31'd0, err_o}, 32'd0);
        chk("reset vld", {31'd0, vld_o}, 32'd0);

        for (int i = 0; i < 22; i++)
            cyc(tbl[i].r, tbl[i].a, tbl[i].w, tbl[i].g, tbl[i].v,
                tbl[i].ereq, tbl[i].egnt, tbl[i].evld, tbl[i].eerr,
                $sformatf("vec%0d", i));
        after_edge_cnt("vec end", 3'd0);

        // Full counter with simultaneous push and pop on bank 0.
        do_reset();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 2'd0, 1'b0, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, 1'b0, "full fill");
        after_edge_cnt("full fill", 3'd4);
        cyc(1'b1, 2'd0, 1'b0, 4'hF, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, "full pushpop");
        after_edge_cnt("full pushpop", 3'd4);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 2'd0, 1'b0, 4'hF, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, "full drain");
        after_edge_cnt("full drain", 3'd0);

        // Bank switch on the drain cycle, with explicit state check.
        do_reset();
        cyc(1'b1, 2'd1, 1'b0, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, 1'b0, "sw issue");
        cyc(1'b1, 2'd3, 1'b0, 4'hF, 4'b0010, 4'b1000, 1'b1, 1'b1, 1'b0, "sw switch");
        after_edge_cnt("sw switch", 3'd1);
        chk("sw bank", {30'd0, dut.bank_q}, 32'd3);

        // Write suppression: untracked write bypasses the in-flight reads.
        do_reset();
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 2'd0, 1'b0, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, 1'b0, "nw reads");
        cyc(1'b1, 2'd2, 1'b1, 4'hF, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b0, "nw write tracked");
        chk("nw write req_o", {28'd0, nw_req_o}, 32'b0100);
        chk("nw write gnt_o", {31'd0, nw_gnt_o}, 32'd1);
        @(posedge clk); #1;
        chk("nw cnt", {29'd0, dut_nw.cnt_q}, 32'd3);
        chk("nw bank", {30'd0, dut_nw.bank_q}, 32'd0);
        @(negedge clk);
        req_i = 1'b1; add_i = 2'd2; wen_i = 1'b0; #1;
        chk("nw read gated", {28'd0, nw_req_o}, 32'd0);

        // Unexpected valid sets the sticky error; only reset clears it.
        do_reset();
        cyc(1'b0, 2'd0, 1'b0, 4'h0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, "err inject");
        cyc(1'b0, 2'd0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, "err set");
        cyc(1'b0, 2'd0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, "err hold");
        do_reset();
        chk("err cleared", {31'd0, err_o}, 32'd0);

        // Reset mid-flight drops tracking; a late response is an error.
        cyc(1'b1, 2'd1, 1'b0, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, 1'b0, "mid issue");
        cyc(1'b1, 2'd1, 1'b0, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, 1'b0, "mid issue");
        do_reset();
        chk("mid cnt", {29'd0, dut.cnt_q}, 32'd0);
        cyc(1'b1, 2'd3, 1'b0, 4'h0, 4'h0, 4'b1000, 1'b0, 1'b0, 1'b0, "mid nognt");
        cyc(1'b1, 2'd3, 1'b0, 4'b1000, 4'h0, 4'b1000, 1'b1, 1'b0, 1'b0, "mid gnt");
        cyc(1'b0, 2'd0, 1'b0, 4'h0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, "mid late vld");
        cyc(1'b0, 2'd0, 1'b0, 4'h0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, "mid err");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addr_dec_resp_mux_varlat_mo.md
Name: addr_dec_resp_mux_varlat_mo

Overview:
Per-master address decoder and response mux for the variable-latency TCDM crossbar. It supports up to MaxOutstanding in-flight transactions instead of one. In-order responses are guaranteed by allowing outstanding transactions to only one bank at a time. A bank switch is permitted once that bank has drained, including in the same cycle its last response returns. Optional write-response suppression and a sticky protocol-error flag are added.

Parameters:
NumOut, 32, number of slave ports (banks); must be >= 1
ReqDataWidth, 32, request payload width
RespDataWidth, 32, response data width
MaxOutstanding, 4, maximum in-flight transactions per master; must be >= 1
WriteRespOn, 1'b1, 1: writes return vld_i and are tracked; 0: writes are fire-and-forget and are not counted

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
req_i  in  1  master request
add_i  in  max(1,$clog2(NumOut))  bank index
wen_i  in  1  write enable (1 = write)
data_i  in  ReqDataWidth  request payload
gnt_o  out  1  grant to master
vld_o  out  1  response valid to master
rdata_o  out  RespDataWidth  response data
err_o  out  1  sticky error: unexpected vld_i observed
req_o  out  NumOut  decoded one-hot request
gnt_i  in  NumOut  slave grants
vld_i  in  NumOut  slave response valids
data_o  out  NumOut x ReqDataWidth  payload replicated to every slave
rdata_i  in  NumOut x RespDataWidth  slave responses

Behaviour:
- State: cnt_q (width $clog2(MaxOutstanding+1)); bank_q; err_q. Reset (rst_i=1 at clk_i edge): cnt_q=0, bank_q=0, err_q=0. A reset mid-operation discards all in-flight tracking; late vld_i arriving after reset sets err_o.
- tracked = ~wen_i | WriteRespOn.
- pop = (cnt_q!=0) & vld_i[bank_q].
- drained = (cnt_q==0) | (cnt_q==1 & pop).
- accept_ok = ~tracked | drained | (add_i==bank_q & (cnt_q<MaxOutstanding | pop)).
- req_o[add_i] = req_i & accept_ok; all other bits of req_o are 0. Requests are gated, never dropped; the master holds req_i until gnt_o.
- gnt_o = req_i & accept_ok & gnt_i[add_i]. It is combinational, zero latency, and never asserted while req_o is gated.
- push = gnt_o & tracked.
- cnt_d = cnt_q + push - pop. Push and pop in the same cycle leave the count unchanged, including at full. The counter never exceeds MaxOutstanding and never underflows.
- bank_q <= add_i on push. Under the rules above this only changes the bank when it is drained.
- vld_o = pop. rdata_o = rdata_i[bank_q] (combinational pass-through; the value is don't-care when vld_o=0).
- Untracked writes (WriteRespOn=0 & wen_i) are forwarded whenever req_i is high, independent of cnt_q. Any vld_i they cause counts as unexpected.
- err_q <= err_q | (|(vld_i & ~pop_mask)), where pop_mask is one-hot at bank_q when cnt_q!=0 and zero otherwise. This flags any valid from a non-head bank, or any valid while nothing is outstanding. err_o = err_q; it is cleared only by reset.
- data_o: every lane = data_i.
- NumOut==1: bank_q is constant 0, add_i is ignored, and the same counter rules apply.
- MaxOutstanding==1 reproduces single-outstanding behaviour with back-to-back issue allowed on the response cycle.

Decomposition:
- Package tcdm_varlat_pkg: the cnt width function clog2p1(MaxOutstanding) and a bank-index type helper; no per-instance typedefs beyond these.
- Sub-module: none required. The outstanding tracker (counter, bank_q, accept_ok) is kept inline, being under 60 lines.
- Elaboration-time checks: NumOut>0 and MaxOutstanding>0, otherwise $fatal.

Test Plan:
- Burst to one bank: NumOut=4, MaxOutstanding=4, 4 reads to bank 2 with gnt_i always high, then vld_i[2] over 4 later cycles -> 4 grants on consecutive cycles; 5th request gated (req_o=0) until first vld; vld_o pulses 4 times with rdata_o=rdata_i[2]; err_o=0.
- Bank switch on drain: 1 outstanding to bank 1; request to bank 3 held; vld_i[1] asserted -> same cycle req_o=4'b1000, gnt_o=1, vld_o=1; next cycle cnt=1, bank_q=3.
- Full with simultaneous push/pop: cnt=MaxOutstanding on bank 0, vld_i[0] and new req to bank 0 with gnt_i[0]=1 in the same cycle -> gnt_o=1, vld_o=1, cnt unchanged.
- Write suppression: WriteRespOn=0, 3 outstanding reads to bank 0, write to bank 2 -> write granted immediately, cnt stays 3, bank_q stays 0.
- Error detection: cnt=0, inject vld_i[1] -> err_o=1 from next cycle and held; vld_o=0. Assert rst_i -> err_o=0 after the edge.
- Reset mid-flight: 2 outstanding, rst_i pulsed -> cnt=0, gnt_o follows gnt_i[add_i] for a new request; a late vld_i sets err_o.
